// File: rtl/iddmm_host_ctrl_if.sv
// Host-side bundle for iddmm_host_ctrl. It carries the operand load and start
// request from the host, the word-write stream and task handshake toward the
// multiplier, and the assembled result back to the host.
interface iddmm_host_ctrl_if #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
);
  logic                start;
  logic [2:0]          ena_mask;
  logic [K*N-1:0]      op_x;
  logic [K*N-1:0]      op_y;
  logic [K*N-1:0]      op_m;
  logic [K-1:0]        op_m1;
  logic                busy;
  logic                done;
  logic                err;
  logic [K*N-1:0]      result;
  logic [2:0]          wr_ena;
  logic [ADDR_W-1:0]   wr_addr;
  logic [K-1:0]        wr_x;
  logic [K-1:0]        wr_y;
  logic [K-1:0]        wr_m;
  logic [K-1:0]        wr_m1;
  logic                task_req;
  logic                task_grant;
  logic [K-1:0]        task_res;
  logic                task_end;

  // Environment view: host plus multiplier model.
  modport master (
    output start, ena_mask, op_x, op_y, op_m, op_m1,
    output task_grant, task_res, task_end,
    input  busy, done, err, result,
    input  wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req
  );

  // Controller view.
  modport slave (
    input  start, ena_mask, op_x, op_y, op_m, op_m1,
    input  task_grant, task_res, task_end,
    output busy, done, err, result,
    output wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req
  );
endinterface

// File: rtl/iddmm_host_ctrl.sv
// Host controller for a word-serial Montgomery multiplier: latches the operands
// on start, streams them into the multiplier word by word, fires one task
// request, then assembles the returned result words (with a first-grant timeout).
module iddmm_host_ctrl #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int ADDR_W  = $clog2(N),
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  iddmm_host_ctrl_if.slave bus
);

  // One spare bit so a count of N words never wraps when N is a power of two.
  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CNT_W-1:0]  cnt;       // word address in LOAD, word index in COLLECT
  logic [TO_W-1:0]   tcnt;      // cycles waited for the first grant
  logic [K*N-1:0]    x_q;
  logic [K*N-1:0]    y_q;
  logic [K*N-1:0]    m_q;
  logic [K-1:0]      m1_q;
  logic [2:0]        mask_q;
  logic [K*N-1:0]    result_q;
  logic              err_q;

  logic [ADDR_W-1:0] widx;
  logic              load_last;
  logic              collect_last;
  logic              timeout_hit;

  assign widx         = cnt[ADDR_W-1:0];
  assign load_last    = (cnt == CNT_W'(N - 1));
  assign collect_last = bus.task_grant && (cnt == CNT_W'(N - 1));
  // Only armed while no word has arrived yet; a grant on the last cycle wins.
  assign timeout_hit  = !bus.task_grant && (cnt == '0) &&
                        (tcnt == TO_W'(TIMEOUT - 1));

  assign bus.err    = err_q;
  assign bus.result = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state outputs; write bus is zero outside LOAD.
  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.task_req = 1'b0;
    bus.wr_ena   = 3'b000;
    bus.wr_addr  = '0;
    bus.wr_x     = '0;
    bus.wr_y     = '0;
    bus.wr_m     = '0;
    bus.wr_m1    = '0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_nxt = (bus.ena_mask == 3'b000) ? S_REQ : S_LOAD;
        end
      end
      S_LOAD: begin
        bus.wr_ena  = mask_q;
        bus.wr_addr = widx;
        bus.wr_x    = x_q[widx*K +: K];
        bus.wr_y    = y_q[widx*K +: K];
        bus.wr_m    = m_q[widx*K +: K];
        bus.wr_m1   = m1_q;
        if (load_last) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        bus.task_req = 1'b1;
        state_nxt    = S_COLLECT;
      end
      S_COLLECT: begin
        if (collect_last) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch, word/timeout counters, result assembly and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      tcnt     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      m_q      <= '0;
      m1_q     <= '0;
      mask_q   <= 3'b000;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            x_q      <= bus.op_x;
            y_q      <= bus.op_y;
            m_q      <= bus.op_m;
            m1_q     <= bus.op_m1;
            mask_q   <= bus.ena_mask;
            result_q <= '0;
            cnt      <= '0;
            tcnt     <= '0;
          end
        end
        S_LOAD: begin
          cnt <= load_last ? '0 : cnt + 1'b1;
        end
        S_REQ: begin
          cnt  <= '0;
          tcnt <= '0;
        end
        S_COLLECT: begin
          if (bus.task_grant) begin
            result_q[widx*K +: K] <= bus.task_res;
            cnt                   <= collect_last ? '0 : cnt + 1'b1;
          end else if (cnt == '0) begin
            if (timeout_hit) begin
              err_q <= 1'b1;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iddmm_host_ctrl.sv
// Scoreboard bench for iddmm_host_ctrl: stimulus pushes the expected write,
// request, done and error events (derived from the latency rules), and a
// negedge monitor pops and compares them as the DUTs present them.
module tb_iddmm_host_ctrl;
  localparam int K    = 128;
  localparam int N4   = 4;
  localparam int N32  = 32;
  localparam int TO4  = 16;
  localparam int TO32 = 64;
  localparam int RW   = K * N32;

  typedef struct {
    int         cyc;
    logic [2:0] ena;
    int         addr;
    logic [K-1:0] x, y, m, m1;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [RW-1:0] res;
  } dn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  wr_t  wq[$];
  int   rq[$];
  int   eq[$];
  dn_t  dq[$];
  int   gq[$];
  logic [K-1:0] rwq[$];
  bit   bchk4 = 1'b0;
  bit   bchk32 = 1'b0;

  iddmm_host_ctrl_if #(.K(K), .N(N4))  bus4 ();
  iddmm_host_ctrl_if #(.K(K), .N(N32)) bus32 ();

  iddmm_host_ctrl #(.K(K), .N(N4), .TIMEOUT(TO4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  iddmm_host_ctrl #(.K(K), .N(N32), .TIMEOUT(TO32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_res(input string nm, input int n, input logic [RW-1:0] act,
                           input logic [RW-1:0] exp);
    int bad;
    bad = -1;
    n_tests++;
    for (int i = 0; i < n; i++)
      if (bad < 0 && act[i*K +: K] !== exp[i*K +: K]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s word %0d: got %0h, expected %0h", nm, bad,
               act[bad*K +: K], exp[bad*K +: K]);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected or missing event (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [K-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [RW-1:0] rnd_wide();
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Compare one DUT's outputs against the head of the expectation queues.
  task automatic observe(input bit big, input logic [2:0] ena, input int addr,
                         input logic [K-1:0] x, input logic [K-1:0] y,
                         input logic [K-1:0] m, input logic [K-1:0] m1,
                         input logic req, input logic dn, input logic er,
                         input logic bsy, input logic [RW-1:0] res);
    wr_t   w;
    dn_t   d;
    int    e;
    string tag;
    tag = big ? "n32" : "n4";
    if (big ? bchk32 : bchk4) begin
      check({tag, " busy after done"}, K'(bsy), '0);
      if (big) bchk32 = 1'b0; else bchk4 = 1'b0;
    end
    if (ena != 3'b000) begin
      if (wq.size() == 0) fail_now({tag, " write"});
      else begin
        w = wq.pop_front();
        check({tag, " wr cycle"}, K'(cyc), K'(w.cyc));
        check({tag, " wr_ena"}, K'(ena), K'(w.ena));
        check({tag, " wr_addr"}, K'(addr), K'(w.addr));
        check({tag, " wr_x"}, x, w.x);
        check({tag, " wr_y"}, y, w.y);
        check({tag, " wr_m"}, m, w.m);
        check({tag, " wr_m1"}, m1, w.m1);
      end
    end else begin
      check({tag, " wr idle zero"}, x | y | m | m1 | K'(addr), '0);
    end
    if (req) begin
      if (rq.size() == 0) fail_now({tag, " task_req"});
      else begin
        e = rq.pop_front();
        check({tag, " task_req cycle"}, K'(cyc), K'(e));
      end
    end
    if (dn) begin
      if (dq.size() == 0) fail_now({tag, " done"});
      else begin
        d = dq.pop_front();
        check({tag, " done cycle"}, K'(cyc), K'(d.cyc));
        check_res({tag, " result"}, big ? N32 : N4, res, d.res);
        if (big) bchk32 = 1'b1; else bchk4 = 1'b1;
      end
    end
    if (er) begin
      if (eq.size() == 0) fail_now({tag, " err"});
      else begin
        e = eq.pop_front();
        check({tag, " err cycle"}, K'(cyc), K'(e));
        check({tag, " busy at err"}, K'(bsy), '0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      observe(1'b0, bus4.wr_ena, int'(bus4.wr_addr), bus4.wr_x, bus4.wr_y, bus4.wr_m,
              bus4.wr_m1, bus4.task_req, bus4.done, bus4.err, bus4.busy, RW'(bus4.result));
      observe(1'b1, bus32.wr_ena, int'(bus32.wr_addr), bus32.wr_x, bus32.wr_y, bus32.wr_m,
              bus32.wr_m1, bus32.task_req, bus32.done, bus32.err, bus32.busy, bus32.result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input bit big, input logic st, input logic [2:0] mask,
                           input logic [RW-1:0] x, input logic [RW-1:0] y,
                           input logic [RW-1:0] m, input logic [K-1:0] m1);
    if (big) begin
      bus32.start = st; bus32.ena_mask = mask;
      bus32.op_x = x; bus32.op_y = y; bus32.op_m = m; bus32.op_m1 = m1;
    end else begin
      bus4.start = st; bus4.ena_mask = mask;
      bus4.op_x = x[K*N4-1:0]; bus4.op_y = y[K*N4-1:0]; bus4.op_m = m[K*N4-1:0];
      bus4.op_m1 = m1;
    end
  endtask

  task automatic set_grant(input bit big, input logic g, input logic [K-1:0] r);
    if (big) begin bus32.task_grant = g; bus32.task_res = r; end
    else begin bus4.task_grant = g; bus4.task_res = r; end
  endtask

  // Issue one start and record the expected write stream and request cycle.
  task automatic do_start(input bit big, input logic [2:0] mask, input logic [RW-1:0] x,
                          input logic [RW-1:0] y, input logic [RW-1:0] m,
                          input logic [K-1:0] m1);
    int  n;
    int  c;
    wr_t w;
    n = big ? N32 : N4;
    c = cyc;
    drive_ops(big, 1'b1, mask, x, y, m, m1);
    if (mask != 3'b000) begin
      for (int j = 0; j < n; j++) begin
        w.cyc = c + 1 + j; w.ena = mask; w.addr = j;
        w.x = x[j*K +: K]; w.y = y[j*K +: K]; w.m = m[j*K +: K]; w.m1 = m1;
        wq.push_back(w);
      end
    end
    rq.push_back(mask != 3'b000 ? c + n + 1 : c + 1);
    tick();
    drive_ops(big, 1'b0, 3'($urandom()), rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
  endtask

  // Multiplier model: wait for task_req, then grant words rwq[i] at request
  // cycle + gq[i]. With ngr == 0 it expects the first-grant timeout instead.
  task automatic respond(input bit big, input int ngr, output logic [RW-1:0] exp);
    int  n;
    int  rc;
    dn_t d;
    n = big ? N32 : N4;
    rc = -1;
    exp = '0;
    for (int t = 0; t < 300 && rc < 0; t++) begin
      if ((big ? bus32.task_req : bus4.task_req) == 1'b1) rc = cyc;
      else tick();
    end
    if (rc < 0) begin
      fail_now("task_req wait expired");
      return;
    end
    if (ngr == 0) begin
      eq.push_back(rc + 1 + (big ? TO32 : TO4));
      return;
    end
    for (int i = 0; i < ngr; i++) begin
      while (cyc < rc + gq[i]) begin
        set_grant(big, 1'b0, rnd_word());
        tick();
      end
      set_grant(big, 1'b1, rwq[i]);
      exp[i*K +: K] = rwq[i];
      if (i == n - 1) begin
        d.cyc = rc + gq[i] + 1;
        d.res = exp;
        dq.push_back(d);
      end
      tick();
    end
    set_grant(big, 1'b0, rnd_word());
  endtask

  task automatic wait_idle(input bit big);
    int t;
    t = 0;
    while ((big ? bus32.busy : bus4.busy) && t < 500) begin
      tick();
      t++;
    end
    check("return to idle", K'(big ? bus32.busy : bus4.busy), '0);
    tick();
    tick();
  endtask

  task automatic rand_grants(input int n, input int maxgap);
    int g;
    g = 0;
    gq = {};
    rwq = {};
    for (int i = 0; i < n; i++) begin
      g += $urandom_range(maxgap, 1);
      gq.push_back(g);
      rwq.push_back(rnd_word());
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] x, y, m, exp;
    logic [K-1:0]  m1;
    drive_ops(1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    drive_ops(1'b1, 1'b0, 3'b000, '0, '0, '0, '0);
    set_grant(1'b0, 1'b0, '0);
    set_grant(1'b1, 1'b0, '0);
    bus4.task_end = 1'b0;
    bus32.task_end = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("reset busy", K'(bus4.busy), '0);
    check("reset done", K'(bus4.done), '0);
    check("reset err", K'(bus4.err), '0);
    check("reset task_req", K'(bus4.task_req), '0);
    check("reset wr_ena", K'(bus4.wr_ena), '0);
    check_res("reset result", N4, RW'(bus4.result), '0);
    rst = 1'b0;

    // Basic run, started on the first edge out of reset.
    x = '0;
    for (int i = 0; i < N4; i++) x[i*K +: K] = K'(i + 1);
    y = rnd_wide(); m = rnd_wide(); m1 = rnd_word();
    do_start(1'b0, 3'b111, x, y, m, m1);
    gq = '{1, 2, 3, 4};
    rwq = '{128'hA0, 128'hA1, 128'hA2, 128'hA3};
    respond(1'b0, N4, exp);
    wait_idle(1'b0);

    // A grant in IDLE leaves result and state alone.
    set_grant(1'b0, 1'b1, rnd_word());
    tick();
    set_grant(1'b0, 1'b0, '0);
    tick();
    check_res("n4 result hold", N4, RW'(bus4.result), exp);
    check("n4 idle grant busy", K'(bus4.busy), '0);

    // Mask 001.
    do_start(1'b0, 3'b001, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    rand_grants(N4, 1);
    respond(1'b0, N4, exp);
    wait_idle(1'b0);

    // Mask 000: straight to the request.
    do_start(1'b0, 3'b000, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    rand_grants(N4, 3);
    respond(1'b0, N4, exp);
    wait_idle(1'b0);

    // Gapped grants, with a stray grant during LOAD.
    do_start(1'b0, 3'b110, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    set_grant(1'b0, 1'b1, rnd_word());
    tick();
    set_grant(1'b0, 1'b0, '0);
    rand_grants(N4, 1);
    gq = '{2, 5, 6, 9};
    respond(1'b0, N4, exp);
    wait_idle(1'b0);

    // Timeout with no grant.
    do_start(1'b0, 3'b011, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    respond(1'b0, 0, exp);
    wait_idle(1'b0);
    check_res("n4 result after timeout", N4, RW'(bus4.result), '0);

    // Reset in COLLECT after two grants, then a full run.
    do_start(1'b0, 3'b111, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    rand_grants(2, 2);
    respond(1'b0, 2, exp);
    tick();
    rst = 1'b1;
    wq = {}; rq = {}; eq = {}; dq = {};
    tick();
    rst = 1'b0;
    check("rst busy", K'(bus4.busy), '0);
    check("rst done", K'(bus4.done), '0);
    check("rst err", K'(bus4.err), '0);
    check("rst task_req", K'(bus4.task_req), '0);
    check("rst wr_ena", K'(bus4.wr_ena), '0);
    check("rst wr bus", bus4.wr_x | bus4.wr_y | bus4.wr_m | bus4.wr_m1 | K'(bus4.wr_addr), '0);
    check_res("rst result", N4, RW'(bus4.result), '0);
    do_start(1'b0, 3'b111, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    rand_grants(N4, 3);
    respond(1'b0, N4, exp);
    wait_idle(1'b0);

    // Second start during LOAD is ignored.
    do_start(1'b0, 3'b111, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    drive_ops(1'b0, 1'b1, 3'b101, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    tick();
    drive_ops(1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    rand_grants(N4, 2);
    respond(1'b0, N4, exp);
    wait_idle(1'b0);

    // Full-width run at N=32.
    do_start(1'b1, 3'b111, rnd_wide(), rnd_wide(), rnd_wide(), rnd_word());
    rand_grants(N32, 3);
    respond(1'b1, N32, exp);
    wait_idle(1'b1);

    check("leftover writes", K'(wq.size()), '0);
    check("leftover task_req", K'(rq.size()), '0);
    check("leftover done", K'(dq.size()), '0);
    check("leftover err", K'(eq.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
